ysyx_23060171_ifu: RTL and testbench

Instruction fetch responder on the far side of the core's pc/inst interface. It accepts a fetch request carrying the core's pc and issues a single-beat read on the instruction-memory read channel (AR/R valid-ready). It returns the 32-bit instruction to the core with a valid/ready handshake. It replaces the combinational pc-to-inst path so that memory can have variable latency.

---
 rtl/ysyx_23060171_ifu.sv | 155 +++++++++++++++
 tb/tb_ysyx_23060171_ifu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060171_ifu.sv
// Fetch responder: pc request -> single-beat AR/R read -> inst valid/ready; LAST_HIT_EN adds a one-entry last-fetch buffer.
// Latency: aligned miss 3 cycles with a zero-wait memory, misaligned pc or buffer hit 1 cycle.
// Backpressure: AR held until arready, rready only in R, inst held until inst_ready; one read outstanding.
module ysyx_23060171_ifu #(
  parameter logic [31:0] RESET_INST = 32'h00000013,
  parameter int          ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid,
  output logic [31:0]       inst_o,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              inst_err,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [31:0]       mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       inst_q;
  logic              err_q;
  logic              accept;
  logic              misalign;
  logic              hit;
  logic [31:0]       hit_dat;
  logic              r_done;

  // OUT accepts the next pc on the same cycle as the core handshake, so there is no bubble.
  assign accept   = pc_valid && ((state_q == IDLE) || ((state_q == OUT) && inst_ready));
  assign misalign = (pc_i[1:0] != 2'b00);
  assign r_done   = (state_q == R) && mem_rvalid;

`ifdef LAST_HIT_EN
  logic              buf_vld;
  logic [ADDR_W-1:0] buf_tag;
  logic [31:0]       buf_dat;

  // A flush in the hit cycle forces a miss.
  assign hit     = buf_vld && !flush && (buf_tag == pc_i);
  assign hit_dat = buf_dat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld <= 1'b0;
      buf_tag <= '0;
      buf_dat <= '0;
    end else if (flush) begin
      buf_vld <= 1'b0;
    end else if (r_done && (mem_rresp == 2'b00)) begin
      buf_vld <= 1'b1;
      buf_tag <= addr_q;
      buf_dat <= mem_rdata;
    end
  end
`else
  logic unused_flush;

  assign unused_flush = flush;
  assign hit          = 1'b0;
  assign hit_dat      = RESET_INST;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (misalign || hit) ? OUT : AR;
        end
      end
      AR: begin
        if (mem_arready) begin
          state_d = R;
        end
      end
      R: begin
        if (mem_rvalid) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (inst_ready) begin
          if (accept) begin
            state_d = (misalign || hit) ? OUT : AR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      inst_q    <= RESET_INST;
      err_q     <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      if ((state_q == OUT) && inst_ready) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (accept) begin
        addr_q <= pc_i;
        if (misalign) begin
          inst_q <= RESET_INST;
          err_q  <= 1'b1;
        end else if (hit) begin
          inst_q <= hit_dat;
          err_q  <= 1'b0;
        end
      end else if (r_done) begin
        inst_q <= (mem_rresp != 2'b00) ? RESET_INST : mem_rdata;
        err_q  <= (mem_rresp != 2'b00);
      end
    end
  end

  always_comb begin
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    inst_valid  = 1'b0;
    case (state_q)
      AR:      mem_arvalid = 1'b1;
      R:       mem_rready  = 1'b1;
      OUT:     inst_valid  = 1'b1;
      default: ;
    endcase
  end

  assign mem_araddr = addr_q;
  assign inst_o     = inst_q;
  assign inst_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060171_ifu.sv
// Bench for ysyx_23060171_ifu: directed fetches, a scripted memory responder and a scoreboard of returned instructions.
module tb_ysyx_23060171_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        inst_ready;
  logic        inst_err;
  logic        flush;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] fetch_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb_inst[$];
  logic        sb_err[$];

  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [31:0] m_rdata  = 32'h0;
  logic [1:0]  m_rresp  = 2'b00;
  logic [31:0] exp_addr = 32'h0;
  int          ar_seen  = 0;
  logic [31:0] exp_cnt  = 32'h0;

  ysyx_23060171_ifu dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .pc_valid   (pc_valid),
    .inst_o     (inst_o),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_err   (inst_err),
    .flush      (flush),
    .mem_araddr (mem_araddr),
    .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready),
    .mem_rdata  (mem_rdata),
    .mem_rresp  (mem_rresp),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: counts wait cycles per channel and checks the address while AR is pending.
  initial begin
    int ar_cnt;
    int r_cnt;
    ar_cnt = 0;
    r_cnt  = 0;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;
    mem_rresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (mem_arvalid) begin
        ar_seen++;
        check32("araddr", mem_araddr, exp_addr);
        mem_arready = (ar_cnt == ar_delay);
        if (ar_cnt == ar_delay) ar_cnt = 0;
        else ar_cnt++;
      end else begin
        mem_arready = 1'b0;
        ar_cnt = 0;
      end
      if (mem_rready) begin
        mem_rvalid = (r_cnt == r_delay);
        mem_rdata  = m_rdata;
        mem_rresp  = m_rresp;
        if (r_cnt == r_delay) r_cnt = 0;
        else r_cnt++;
      end else begin
        mem_rvalid = 1'b0;
        r_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every core handshake consumes one expected response.
  initial begin
    logic [31:0] ei;
    logic        ee;
    forever begin
      @(negedge clk);
      if (rst && inst_valid && inst_ready) begin
        if (sb_inst.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got inst %h with no expected entry", inst_o);
        end else begin
          ei = sb_inst.pop_front();
          ee = sb_err.pop_front();
          check32("sb_inst", inst_o, ei);
          check32("sb_err", {31'b0, inst_err}, {31'b0, ee});
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp_inst, input logic exp_err,
                       input int exp_lat, input int hold, input logic exp_mem);
    int lat;
    int ar0;
    exp_addr = pc;
    ar0 = ar_seen;
    sb_inst.push_back(exp_inst);
    sb_err.push_back(exp_err);
    @(posedge clk); #1;
    pc_i = pc;
    pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_i = 32'h12345679;
    lat = 1;
    while (!inst_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    pc_valid = 1'b0;
    check32("latency", lat, exp_lat);
    check32("mem_access", {31'b0, ar_seen != ar0}, {31'b0, exp_mem});
    repeat (hold) begin
      check32("hold_valid", {31'b0, inst_valid}, 32'd1);
      check32("hold_inst", inst_o, exp_inst);
      check32("hold_err", {31'b0, inst_err}, {31'b0, exp_err});
      check32("hold_cnt", fetch_cnt, exp_cnt);
      @(posedge clk); #1;
    end
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    check32("fetch_cnt", fetch_cnt, exp_cnt);
    check32("idle_after", {31'b0, inst_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b0;
    pc_i = 32'h0;
    pc_valid = 1'b0;
    inst_ready = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_inst", inst_o, 32'h00000013);
    check32("rst_valid", {31'b0, inst_valid}, 32'd0);
    check32("rst_err", {31'b0, inst_err}, 32'd0);
    check32("rst_arvalid", {31'b0, mem_arvalid}, 32'd0);
    check32("rst_rready", {31'b0, mem_rready}, 32'd0);
    check32("rst_araddr", mem_araddr, 32'h0);
    check32("rst_cnt", fetch_cnt, 32'h0);
    rst = 1'b1;

    m_rdata = 32'h00100093;
    fetch(32'h80000000, 32'h00100093, 1'b0, 3, 0, 1'b1);

    ar_delay = 4;
    r_delay  = 3;
    m_rdata  = 32'h00500293;
    fetch(32'h80000010, 32'h00500293, 1'b0, 10, 0, 1'b1);
    ar_delay = 0;
    r_delay  = 0;

    fetch(32'h80000002, 32'h00000013, 1'b1, 1, 1, 1'b0);

    m_rdata = 32'hffffffff;
    m_rresp = 2'b10;
    fetch(32'h80000020, 32'h00000013, 1'b1, 3, 5, 1'b1);
    m_rresp = 2'b00;

    // Back-to-back request on the handshake cycle, then reset while the read is pending.
    m_rdata = 32'h00200113;
    exp_addr = 32'h80000030;
    sb_inst.push_back(32'h00200113);
    sb_err.push_back(1'b0);
    @(posedge clk); #1;
    pc_i = 32'h80000030;
    pc_valid = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    lat = 1;
    while (!inst_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check32("b2b_first_lat", lat, 3);
    r_delay = 10;
    exp_addr = 32'h80000004;
    pc_i = 32'h80000004;
    pc_valid = 1'b1;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    pc_valid = 1'b0;
    inst_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    check32("b2b_arvalid", {31'b0, mem_arvalid}, 32'd1);
    check32("b2b_valid", {31'b0, inst_valid}, 32'd0);
    check32("b2b_cnt", fetch_cnt, exp_cnt);
    @(posedge clk); #1;
    check32("b2b_rready", {31'b0, mem_rready}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check32("arst_arvalid", {31'b0, mem_arvalid}, 32'd0);
    check32("arst_rready", {31'b0, mem_rready}, 32'd0);
    check32("arst_valid", {31'b0, inst_valid}, 32'd0);
    check32("arst_inst", inst_o, 32'h00000013);
    check32("arst_cnt", fetch_cnt, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    r_delay = 0;
    exp_cnt = 32'h0;

`ifdef LAST_HIT_EN
    m_rdata = 32'h00100093;
    fetch(32'h80000000, 32'h00100093, 1'b0, 3, 0, 1'b1);
    m_rdata = 32'hdeadbeef;
    fetch(32'h80000000, 32'h00100093, 1'b0, 1, 0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    fetch(32'h80000000, 32'hdeadbeef, 1'b0, 3, 0, 1'b1);
`else
    m_rdata = 32'h00100093;
    fetch(32'h80000000, 32'h00100093, 1'b0, 3, 0, 1'b1);
    m_rdata = 32'hdeadbeef;
    fetch(32'h80000000, 32'hdeadbeef, 1'b0, 3, 0, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_rdata = 32'h00700393;
    fetch(32'h80000000, 32'h00700393, 1'b0, 3, 0, 1'b1);
`endif

    repeat (2) @(posedge clk);
    check32("sb_drained", sb_inst.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
